uart_rx_sampler: RTL
====================

// Module: uart_rx_sampler
// PURPOSE
//  8N1 UART receiver, the stage directly downstream of the buffered UART transmitter.
//  Recovers bytes from a serial line clocked off the 12 MHz system clock and presents
//  each as a one-cycle data_out_valid strobe. Used for loopback verification of the
//  transmit path and as the on-chip receive front end.
// PARAMETERS
//  CLOCKS_PER_BIT  104  system clocks per bit (104 = ~115,200 baud, 13 = ~921,600 baud); must be >= 8
//  HALF_BIT        CLOCKS_PER_BIT/2  offset from the start-bit falling edge to the mid-bit sample
// PORTS
//  clock           in   1  system clock, 12 MHz
//  reset_n         in   1  asynchronous, active-low reset
//  uart_rx         in   1  serial input, idle high, asynchronous to clock
//  data_out        out  8  last received byte, LSB received first
//  data_out_valid  out  1  one-cycle strobe: data_out is a newly received byte
//  framing_error   out  1  one-cycle strobe: stop bit sampled low
//  busy            out  1  high while state != IDLE
// BEHAVIOUR
//  Reset: data_out=8'h00, data_out_valid=0, framing_error=0, busy=0, state=IDLE,
//   sync flops=1'b1. Reset takes effect immediately, including mid-frame; the partial
//   byte is discarded and no strobe is issued.
//  Input: 2-flop synchronizer (rx_s). All decisions use rx_s only.
//  States: IDLE -> START -> DATA -> STOP -> IDLE, plus BREAK.
//   IDLE : on rx_s==0, clear bit counter, set cycle counter=0, go to START.
//   START: at cycle counter==HALF_BIT-1, sample. If 0, go to DATA and reload the counter.
//    If 1 (glitch/false start), go to IDLE with no strobe.
//   DATA : sample once every CLOCKS_PER_BIT cycles, shifting into shreg[7] with a right
//    shift. After the 8th sample, go to STOP.
//   STOP : sample after CLOCKS_PER_BIT cycles.
//    If 1: data_out<=shreg, pulse data_out_valid for one cycle, go to IDLE.
//    If 0: pulse framing_error for one cycle, leave data_out unchanged, go to BREAK.
//   BREAK: wait for rx_s==1, then go to IDLE. Stuck-low lines are not re-reported.
//  Latency: data_out_valid rises on the clock after the stop-bit sample, at
//   2 (sync) + HALF_BIT + 9*CLOCKS_PER_BIT cycles after the raw falling edge, +/-1.
//  Back-to-back: a new start bit is accepted on the cycle after leaving STOP. This
//   gives a half-bit margin, so continuous frames at the nominal rate are never dropped.
//  Counter: width $clog2(CLOCKS_PER_BIT); wraps to 0 at CLOCKS_PER_BIT-1; never free-runs
//   in IDLE.
//  data_out_valid and framing_error are never high in the same cycle.
//  No backpressure: the consumer must take data_out on the strobe cycle. data_out holds
//   until the next good byte.
//  Baud tolerance: +/-3% mismatch between transmitter and CLOCKS_PER_BIT must decode cleanly.
// CONFIGURATION
//  UART_RX_GLITCH_FILTER_EN defined: every sample (start, data, stop) is the majority vote
//   of rx_s over 3 consecutive cycles ending at the nominal sample point. The START check
//   also uses the vote. Output latency is unchanged, because the vote uses a 3-bit history
//   register.
//  UART_RX_GLITCH_FILTER_EN undefined: every sample is the single rx_s value at the sample
//   point.
// TESTING
//  1. Reset, then CLOCKS_PER_BIT=104, send 0x55 -> exactly one data_out_valid, data_out==8'h55,
//     framing_error stays 0, strobe at 2+52+936 cycles +/-1 after the falling edge.
//  2. Send 256 back-to-back frames 0x00..0xFF with no idle gap -> 256 strobes, in order,
//     no errors.
//  3. Drive uart_rx low for 20 cycles, then high -> no strobe; busy falls at cycle ~54;
//     next frame 0xA3 decodes correctly.
//  4. Send 0x3C with stop bit=0, hold low 500 cycles, then release -> one framing_error
//     strobe, no data_out_valid, state stays BREAK until high; a following 0x81 decodes.
//  5. Assert reset_n low at bit 4 of 0xF0, release, send 0x0F -> no strobe for the first
//     frame; second gives 8'h0F.
//  6. Send 0x00 with a 1-cycle high glitch at each data-bit midpoint -> filter off:
//     data_out==8'hFF; UART_RX_GLITCH_FILTER_EN: data_out==8'h00.
//  7. Transmitter at 101 and 107 clocks/bit, 0xC6 -> decodes 0xC6 with no framing_error.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/framing strobes.
// Optional define UART_RX_GLITCH_FILTER_EN: each sample is a 3-cycle majority vote of rx_s.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | timing half a bit to confirm the start bit
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx_sampler #(
  parameter int CLOCKS_PER_BIT = 104,
  parameter int HALF_BIT       = CLOCKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [2:0]    state;
  logic [1:0]    rx_sync;
  logic          rx_s;
  logic          sample_bit;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], uart_rx};
  end

  assign rx_s = rx_sync[1];

`ifdef UART_RX_GLITCH_FILTER_EN
  // Two previous rx_s values plus the current one form the vote window,
  // so the voted sample lands on the same cycle as the unfiltered one.
  logic [1:0] rx_hist;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_hist <= 2'b11;
    else          rx_hist <= {rx_hist[0], rx_s};
  end

  assign sample_bit = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= sample_bit ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {sample_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (sample_bit) begin
              data_out       <= shreg;
              data_out_valid <= 1'b1;
              state          <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
